nco_sweep_ctrl: RTL and testbench

Sequencer that drives the phase-increment input of the NCO phase accumulator. It performs programmable frequency sweeps from a start increment to a stop increment, in fixed steps, holding each value for a programmed dwell. It runs in one-shot or continuous triangle (bounce) mode and replaces direct button edits of the increment register. It sits in the NCO clock domain; `inc_out` feeds the accumulator's increment register directly.

---
 rtl/nco_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving the NCO phase-increment register.
// Optional button nudge of inc_out in IDLE: define NCO_SWEEP_NUDGE_EN.
module nco_sweep_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               in_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cfg_start,
  input  logic [WIDTH-1:0]   cfg_stop,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
`ifdef NCO_SWEEP_NUDGE_EN
  input  logic               btn_up,
  input  logic               btn_dn,
`endif
  output logic [WIDTH-1:0]   inc_out,
  output logic               inc_valid,
  output logic               busy,
  output logic               done,
  output logic               dir_down,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W-1:0] ONE_D = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   inc_q, inc_d;
  logic [WIDTH-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               dir_q, dir_d;
  logic               tgt_stop_q, tgt_stop_d;
  logic               at_end_q, at_end_d;
  logic               deg_q, deg_d;

  logic [WIDTH:0]     sum_up, sum_dn;
  logic [WIDTH-1:0]   tgt, nxt;
  logic               reached;

  // One extra bit exposes carry (up) or borrow (down) so no leg can wrap.
  always_comb begin
    tgt     = tgt_stop_q ? stop_q : start_q;
    sum_up  = {1'b0, inc_q} + {1'b0, step_q};
    sum_dn  = {1'b0, inc_q} - {1'b0, step_q};
    nxt     = dir_q ? sum_dn[WIDTH-1:0] : sum_up[WIDTH-1:0];
    reached = dir_q ? (sum_dn[WIDTH] || (sum_dn[WIDTH-1:0] <= tgt))
                    : (sum_up[WIDTH] || (sum_up[WIDTH-1:0] >= tgt));
  end

`ifdef NCO_SWEEP_NUDGE_EN
  logic btn_up_q, btn_dn_q;

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_up_q <= 1'b1;
      btn_dn_q <= 1'b1;
    end else begin
      btn_up_q <= btn_up;
      btn_dn_q <= btn_dn;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    inc_d      = inc_q;
    valid_d    = 1'b0;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;
    tgt_stop_d = tgt_stop_q;
    at_end_d   = at_end_q;
    deg_d      = deg_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_d    = cfg_start;
            stop_d     = cfg_stop;
            step_d     = cfg_step;
            dwell_d    = cfg_dwell;
            mode_d     = cfg_mode;
            inc_d      = cfg_start;
            valid_d    = 1'b1;
            dir_d      = (cfg_stop < cfg_start);
            cnt_d      = cfg_dwell;
            tgt_stop_d = 1'b1;
            at_end_d   = 1'b0;
            // Zero step or empty range: hold start, never step.
            deg_d      = (cfg_start == cfg_stop) || (cfg_step == '0);
            state_d    = S_RUN;
          end
`ifdef NCO_SWEEP_NUDGE_EN
          else if (!btn_up && !btn_dn && (btn_up_q || btn_dn_q)) begin
            inc_d   = '0;
            valid_d = 1'b1;
          end else if (btn_up && !btn_up_q) begin
            inc_d   = (&inc_q) ? inc_q : inc_q + ONE_W;
            valid_d = 1'b1;
          end else if (btn_dn && !btn_dn_q) begin
            inc_d   = (inc_q == '0) ? inc_q : inc_q - ONE_W;
            valid_d = 1'b1;
          end
`endif
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_D;
          end else if (deg_q || at_end_q) begin
            if (!mode_q) state_d = S_DONE;
            else         cnt_d   = dwell_q;
          end else begin
            valid_d = 1'b1;
            cnt_d   = dwell_q;
            if (reached) begin
              inc_d = tgt;
              // Triangle turns around on the endpoint write so it is held once.
              if (mode_q) begin
                dir_d      = ~dir_q;
                tgt_stop_d = ~tgt_stop_q;
              end else begin
                at_end_d = 1'b1;
              end
            end else begin
              inc_d = nxt;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      inc_q      <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      mode_q     <= 1'b0;
      tgt_stop_q <= 1'b0;
      at_end_q   <= 1'b0;
      deg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inc_q      <= inc_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
      tgt_stop_q <= tgt_stop_d;
      at_end_q   <= at_end_d;
      deg_q      <= deg_d;
    end
  end

  assign inc_out   = inc_q;
  assign inc_valid = valid_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign dir_down  = dir_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: table-driven one-shot sweeps with a queue scoreboard,
// plus hand-written triangle, abort, start-collision and reset sequences.
module tb_nco_sweep_ctrl;

  logic        in_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        abort  = 1'b0;
  logic [31:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_mode  = 1'b0;
  logic [31:0] inc_out;
  logic        inc_valid, busy, done, dir_down;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic        exp_dir_q[$];

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [31:0] st;
    logic [15:0] dw;
    int          exp_len;   // -1: take length/last value from the model
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  nco_sweep_ctrl #(.WIDTH(32), .DWELL_W(16)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .inc_out(inc_out), .inc_valid(inc_valid), .busy(busy), .done(done),
    .dir_down(dir_down), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 in_clk = ~in_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drive_cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] dw, input logic m);
    cfg_start = s; cfg_stop = e; cfg_step = st; cfg_dwell = dw; cfg_mode = m;
  endtask

  // Reference one-shot sequence with wide arithmetic and explicit clamping.
  task automatic model_push(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            output int n, output logic [31:0] last);
    longint v, tgt, stp;
    bit down;
    exp_q.push_back(s);
    n = 1;
    last = s;
    if (s == e || st == 0) return;
    v = {32'b0, s};
    tgt = {32'b0, e};
    stp = {32'b0, st};
    down = (e < s);
    for (int k = 0; k < 10000; k++) begin
      if (down) v = v - stp;
      else      v = v + stp;
      if ((down && v <= tgt) || (!down && v >= tgt)) begin
        exp_q.push_back(e);
        n++;
        last = e;
        break;
      end
      exp_q.push_back(v[31:0]);
      n++;
      last = v[31:0];
    end
  endtask

  task automatic run_oneshot(input vec_t v, input bit disturb);
    int n_model, nvalid, since;
    bit seen_done;
    logic [31:0] last_model, got;
    exp_q.delete();
    model_push(v.s, v.e, v.st, n_model, last_model);
    if (v.exp_len >= 0) begin
      n_model = v.exp_len;
      last_model = v.exp_last;
    end
    drive_cfg(v.s, v.e, v.st, v.dw, 1'b0);
    start = 1'b1;
    @(negedge in_clk);
    start = 1'b0;
    check("start_latency_valid", inc_valid, 1'b1);
    check("busy_after_start", busy, 1'b1);
    check("dir_after_start", dir_down, v.e < v.s);
    nvalid = 0;
    since = 0;
    seen_done = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (inc_valid) begin
        if (nvalid > 0) check("hold_cycles", since, v.dw + 1);
        if (exp_q.size() == 0) begin
          check("extra_inc_valid", 1'b1, 1'b0);
        end else begin
          got = exp_q.pop_front();
          check("inc_out_seq", inc_out, got);
        end
        nvalid++;
        since = 0;
      end
      if (done) begin
        check("done_after_hold", since, v.dw + 1);
        check("busy_in_done", busy, 1'b0);
        seen_done = 1;
        start = 1'b0;
        break;
      end
      since++;
      if (disturb && cyc == 3) begin
        start = 1'b1;
        drive_cfg($urandom, $urandom, $urandom, 16'($urandom_range(0, 5)), 1'b1);
      end
      if (disturb && cyc == 4) start = 1'b0;
      @(negedge in_clk);
    end
    check("done_seen", seen_done, 1'b1);
    check("valid_count", nvalid, n_model);
    check("final_inc_out", inc_out, last_model);
    check("queue_drained", exp_q.size(), 0);
    @(negedge in_clk);
    check("done_single_pulse", done, 1'b0);
    check("idle_after_done", dbg_state, 2'd0);
    check("inc_retained", inc_out, last_model);
  endtask

  initial begin
    vecs[0] = '{32'd100, 32'd130, 32'd10, 16'd2, 4, 32'd130};
    vecs[1] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2, 32'hFFFF_FFFF};
    vecs[2] = '{32'd500, 32'd900, 32'd0, 16'd3, 1, 32'd500};
    vecs[3] = '{32'd77, 32'd77, 32'd5, 16'd1, 1, 32'd77};
    vecs[4] = '{32'd50, 32'd20, 32'd15, 16'd1, 3, 32'd20};
    vecs[5] = '{32'd30, 32'd0, 32'd40, 16'd0, 2, 32'd0};
    vecs[6] = '{32'd10, 32'd5, 32'd100, 16'd0, 2, 32'd5};
    vecs[7] = '{32'd0, 32'd25, 32'd10, 16'd1, 4, 32'd25};

    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge in_clk);
    check("rst_inc_out", inc_out, 32'd0);
    check("rst_inc_valid", inc_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dir", dir_down, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    @(negedge in_clk);

    // Table-driven one-shot sweeps
    for (int i = 0; i < 8; i++) run_oneshot(vecs[i], 1'b0);

    // Randomised one-shot sweeps, expectations from the model
    for (int i = 0; i < 4; i++) begin
      vec_t rv;
      rv.s = $urandom_range(0, 2000);
      rv.e = $urandom_range(0, 2000);
      rv.st = $urandom_range(50, 400);
      rv.dw = 16'($urandom_range(0, 3));
      rv.exp_len = -1;
      rv.exp_last = '0;
      run_oneshot(rv, 1'b0);
    end

    // start and cfg edits during RUN are ignored
    run_oneshot(vecs[0], 1'b1);

    // Triangle bounce, then abort
    begin
      logic [31:0] tri_vals[7] = '{32'd50, 32'd35, 32'd20, 32'd35, 32'd50, 32'd35, 32'd20};
      bit tri_mid[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      bit tri_dir[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int idx;
      logic [31:0] held, got;
      bit any_bad;
      exp_q.delete();
      for (int k = 0; k < 7; k++) exp_q.push_back(tri_vals[k]);
      drive_cfg(32'd50, 32'd20, 32'd15, 16'd1, 1'b1);
      start = 1'b1;
      @(negedge in_clk);
      start = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
        if (inc_valid) begin
          if (exp_q.size() == 0) begin
            check("tri_extra_valid", 1'b1, 1'b0);
          end else begin
            got = exp_q.pop_front();
            check("tri_inc_out", inc_out, got);
            if (idx < 7 && tri_mid[idx]) check("tri_dir_mid", dir_down, tri_dir[idx]);
          end
          idx++;
        end
        if (done) check("tri_no_done", done, 1'b0);
        if (cyc == 13) begin
          held = inc_out;
          abort = 1'b1;
        end
        @(negedge in_clk);
      end
      abort = 1'b0;
      check("tri_queue_drained", exp_q.size(), 0);
      check("abort_busy", busy, 1'b0);
      check("abort_state", dbg_state, 2'd0);
      check("abort_inc_frozen", inc_out, held);
      check("abort_no_valid", inc_valid, 1'b0);
      any_bad = 0;
      repeat (6) begin
        @(negedge in_clk);
        if (done || inc_valid || busy || inc_out != held) any_bad = 1;
      end
      check("abort_quiet", any_bad, 1'b0);
    end

    // Same-cycle start and abort in IDLE
    begin
      logic [31:0] held;
      held = inc_out;
      drive_cfg(32'd900, 32'd1000, 32'd10, 16'd0, 1'b0);
      start = 1'b1;
      abort = 1'b1;
      @(negedge in_clk);
      start = 1'b0;
      abort = 1'b0;
      check("start_abort_valid", inc_valid, 1'b0);
      check("start_abort_busy", busy, 1'b0);
      check("start_abort_inc", inc_out, held);
      @(negedge in_clk);
      check("start_abort_state", dbg_state, 2'd0);
    end

    // Triangle with start==stop: one load pulse, then hold until abort
    begin
      int nv;
      bit busy_drop;
      drive_cfg(32'd40, 32'd40, 32'd3, 16'd0, 1'b1);
      start = 1'b1;
      @(negedge in_clk);
      start = 1'b0;
      nv = 0;
      busy_drop = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
        if (inc_valid) nv++;
        if (!busy) busy_drop = 1;
        @(negedge in_clk);
      end
      check("tri_flat_valids", nv, 1);
      check("tri_flat_busy", busy_drop, 1'b0);
      check("tri_flat_inc", inc_out, 32'd40);
      abort = 1'b1;
      @(negedge in_clk);
      abort = 1'b0;
      check("tri_flat_abort", dbg_state, 2'd0);
    end

    // Asynchronous reset mid-RUN, then a normal sweep
    drive_cfg(32'd50, 32'd20, 32'd15, 16'd1, 1'b1);
    start = 1'b1;
    @(negedge in_clk);
    start = 1'b0;
    repeat (3) @(negedge in_clk);
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inc_out", inc_out, 32'd0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dir", dir_down, 1'b0);
    check("mid_rst_valid", inc_valid, 1'b0);
    check("mid_rst_state", dbg_state, 2'd0);
    @(negedge in_clk);
    rst_n = 1'b1;
    @(negedge in_clk);
    run_oneshot(vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
